multi_blinker: RTL and testbench
================================

MULTI_BLINKER -- requirements
Module: multi_blinker

Interface
REQ-001 SHALL have parameter N_CH, default 4, the number of independent LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 28, the width of the period, on-time and phase counters.
REQ-003 SHALL have parameter CH_W, default 2, the channel-select width; it SHALL satisfy 2^CH_W >= N_CH.
REQ-004 SHALL have parameter DEF_PERIOD, default 100000000, the reset period in clocks (2 s at 50 MHz).
REQ-005 SHALL have port main_clk, input, width 1: the single 50 MHz clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_valid, input, width 1: a configuration write is offered.
REQ-008 SHALL have port cfg_ready, output, width 1: the block can accept a write.
REQ-009 SHALL have port cfg_ch, input, width CH_W: the target channel.
REQ-010 SHALL have port cfg_mode, input, width 2: 00 OFF, 01 ON, 10 BLINK, 11 BURST.
REQ-011 SHALL have port cfg_period, input, width CNT_W: the period in clocks.
REQ-012 SHALL have port cfg_on_time, input, width CNT_W: the high time per period in clocks.
REQ-013 SHALL have port cfg_burst, input, width 8: the number of periods to run in BURST mode.
REQ-014 SHALL have port LED, output, width N_CH: registered LED drives.
REQ-015 SHALL have port done, output, width N_CH: a one-clock pulse per channel when its burst ends.

Function
REQ-016 SHALL hold the following per-channel registers: mode, period, on_time, cnt, bursts_left.
REQ-017 SHALL take the effective period P as max(period,1).
REQ-018 SHALL accept a write on an edge where cfg_valid=1 and cfg_ready=1.
REQ-019 SHALL drive cfg_ready low for exactly the one clock following each accept, giving a 2-clock minimum write spacing.
REQ-020 SHALL ignore the contents of a write with cfg_ch >= N_CH, while still completing the handshake and applying the cfg_ready low cycle.
REQ-021 SHALL, on the accept edge, load the target channel as follows: mode, period, on_time, bursts_left <= cfg_burst; cnt <= 0; done <= 0.
REQ-022 SHALL, on the accept edge, set LED <= 1 for ON, 0 for OFF, and (0 < on_time) for BLINK or BURST.
REQ-023 SHALL, on every non-accept edge for a BLINK or BURST channel, compute cnt_next = (cnt == P-1) ? 0 : cnt+1, then set cnt <= cnt_next and LED <= (cnt_next < on_time).
REQ-024 SHALL therefore make LED high for exactly min(on_time,P) of every P clocks, starting the clock after accept.
REQ-025 SHALL hold LED steady at 0 when on_time=0, and steady at 1 when on_time >= P.
REQ-026 SHALL hold cnt at 0 for OFF and ON channels, with LED constant.
REQ-027 SHALL, in BURST mode, decrement bursts_left on each wrap edge (cnt == P-1).
REQ-028 SHALL, on the wrap edge where bursts_left goes 1 -> 0, set mode <= OFF and LED <= 0, and pulse done[i] = 1 for one clock.
REQ-029 SHALL treat a BURST accept with cfg_burst=0 as OFF: LED <= 0, and done pulses on the following edge.
REQ-030 SHALL give an accept precedence over a simultaneous wrap or burst end on the same channel: no decrement and no done pulse.
REQ-031 SHALL keep channels independent: a write to one channel SHALL NOT alter the phase of the others.
REQ-032 SHALL use a counter width of CNT_W bits with no overflow past P-1; the done pulse SHALL NOT repeat.

Reset
REQ-033 SHALL, while reset_n=0 and independent of main_clk, set: LED=0, done=0, cfg_ready=0, cnt=0, mode=BLINK, period=DEF_PERIOD, on_time=DEF_PERIOD/2, bursts_left=0.
REQ-034 SHALL raise cfg_ready on the first edge after reset_n rises.
REQ-035 SHALL begin default blinking after release per REQ-023: LED=1 after the first edge, and 50%-duty, 2 s period behaviour thereafter.
REQ-036 SHALL apply a reset asserted mid-burst or mid-write immediately, with no done pulse.

Verification
REQ-037 SHALL cover this scenario: write ch1 BLINK P=10 on=3 -> LED[1] is 1 for clocks 1-3 and 0 for clocks 4-10 after accept, repeating with period 10.
REQ-038 SHALL cover this scenario: write ch2 BURST P=4 on=2 burst=3 -> exactly 3 high pulses of 2 clocks, done[2] is high for one clock at clock 12, and LED[2]=0 afterwards.
REQ-039 SHALL cover these edge cases: on=0, on=P, on>P, P=0, P=1 -> steady 0, steady 1, steady 1, steady 1, steady 1 respectively.
REQ-040 SHALL cover this scenario: cfg_valid held high for 4 clocks -> 2 accepts and cfg_ready toggling 1,0,1,0; a cfg_ch=7 write with N_CH=4 changes nothing.
REQ-041 SHALL cover this scenario: rewrite of a BURST channel on its final wrap edge -> no done pulse, and the new config starts at cnt=0.
REQ-042 SHALL cover this scenario: reset_n pulsed low asynchronously mid-burst -> LED=0, done=0, and cfg_ready=0 immediately; default blink resumes after release.

Source files
------------

// File: rtl/multi_blinker_if.sv
// Configuration write channel for multi_blinker: valid/ready handshake plus
// the per-channel settings that travel with each write.
interface multi_blinker_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 28
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_on_time;
    logic [7:0]       cfg_burst;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_on_time, cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_on_time, cfg_burst,
        output cfg_ready
    );
endinterface

// File: rtl/multi_blinker.sv
// N_CH independent LED channels (OFF / ON / BLINK / BURST), each configured
// through a shared valid/ready write port; LED and done outputs are registered.
module multi_blinker #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned DEF_PERIOD = 100000000
) (
    input  logic                main_clk,
    input  logic                reset_n,
    multi_blinker_if.slave      cfg,
    output logic [N_CH-1:0]     LED,
    output logic [N_CH-1:0]     done
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    logic [1:0]       mode_q   [N_CH];
    logic [1:0]       mode_d   [N_CH];
    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [CNT_W-1:0] on_q     [N_CH];
    logic [CNT_W-1:0] on_d     [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [7:0]       bl_q     [N_CH];
    logic [7:0]       bl_d     [N_CH];

    logic [CNT_W-1:0] p_eff    [N_CH];
    logic [CNT_W-1:0] cnt_nx   [N_CH];
    logic             wrap     [N_CH];

    logic [N_CH-1:0]  led_q, led_d;
    logic [N_CH-1:0]  done_q, done_d;
    logic             rdy_q, rdy_d;
    logic             accept;

    always_comb begin
        accept = cfg.cfg_valid & rdy_q;
        rdy_d  = ~accept;
        led_d  = led_q;
        done_d = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            on_d[i]     = on_q[i];
            cnt_d[i]    = cnt_q[i];
            bl_d[i]     = bl_q[i];
            p_eff[i]    = (period_q[i] == '0) ? CNT_W'(1) : period_q[i];
            wrap[i]     = (cnt_q[i] == p_eff[i] - CNT_W'(1));
            cnt_nx[i]   = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);

            // Channel indices >= N_CH never match, so such writes only consume a handshake.
            if (accept && (cfg.cfg_ch == CH_W'(i))) begin
                mode_d[i]   = cfg.cfg_mode;
                period_d[i] = cfg.cfg_period;
                on_d[i]     = cfg.cfg_on_time;
                bl_d[i]     = cfg.cfg_burst;
                cnt_d[i]    = '0;
                case (cfg.cfg_mode)
                    MODE_OFF: led_d[i] = 1'b0;
                    MODE_ON:  led_d[i] = 1'b1;
                    default:  led_d[i] = (cfg.cfg_on_time != '0);
                endcase
                if (cfg.cfg_mode == MODE_BURST && cfg.cfg_burst == 8'd0)
                    led_d[i] = 1'b0;
            end else if (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BURST) begin
                // A zero-length burst ends on the first edge after its accept.
                if (mode_q[i] == MODE_BURST &&
                    (bl_q[i] == 8'd0 || (wrap[i] && bl_q[i] == 8'd1))) begin
                    mode_d[i] = MODE_OFF;
                    led_d[i]  = 1'b0;
                    done_d[i] = 1'b1;
                    cnt_d[i]  = '0;
                    bl_d[i]   = 8'd0;
                end else begin
                    cnt_d[i] = cnt_nx[i];
                    led_d[i] = (cnt_nx[i] < on_q[i]);
                    if (mode_q[i] == MODE_BURST && wrap[i])
                        bl_d[i] = bl_q[i] - 8'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q  <= '0;
            done_q <= '0;
            rdy_q  <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                mode_q[i]   <= MODE_BLINK;
                period_q[i] <= CNT_W'(DEF_PERIOD);
                on_q[i]     <= CNT_W'(DEF_PERIOD / 2);
                cnt_q[i]    <= '0;
                bl_q[i]     <= 8'd0;
            end
        end else begin
            led_q  <= led_d;
            done_q <= done_d;
            rdy_q  <= rdy_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                on_q[i]     <= on_d[i];
                cnt_q[i]    <= cnt_d[i];
                bl_q[i]     <= bl_d[i];
            end
        end
    end

    assign LED           = led_q;
    assign done          = done_q;
    assign cfg.cfg_ready = rdy_q;

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker: hand-computed LED/done/cfg_ready values
// checked #1 after each rising edge.
module tb_multi_blinker;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 28;
    localparam int unsigned CH_W  = 3;
    localparam int unsigned DEFP  = 16;

    logic            main_clk;
    logic            reset_n;
    logic [N_CH-1:0] LED;
    logic [N_CH-1:0] done;

    multi_blinker_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    multi_blinker #(
        .N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEF_PERIOD(DEFP)
    ) dut (
        .main_clk(main_clk),
        .reset_n (reset_n),
        .cfg     (bus),
        .LED     (LED),
        .done    (done)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 off, 1 on, 2 blink, 3 unchecked (burst in flight)
    int                tm    [N_CH];
    longint unsigned   tp    [N_CH];
    longint unsigned   ton   [N_CH];
    longint unsigned   acc_e [N_CH];
    longint unsigned   ecnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
        ecnt++;
    endtask

    task automatic set_defaults();
        ecnt = 0;
        for (int i = 0; i < N_CH; i++) begin
            tm[i] = 2; tp[i] = DEFP; ton[i] = DEFP / 2; acc_e[i] = 0;
        end
    endtask

    function automatic logic [N_CH-1:0] model_mask();
        logic [N_CH-1:0] m;
        for (int i = 0; i < N_CH; i++) m[i] = (tm[i] != 3);
        return m;
    endfunction

    function automatic logic [N_CH-1:0] model_led();
        logic [N_CH-1:0] v;
        longint unsigned p, k;
        for (int i = 0; i < N_CH; i++) begin
            p = (tp[i] == 0) ? 1 : tp[i];
            k = ecnt - acc_e[i];
            case (tm[i])
                0:       v[i] = 1'b0;
                1:       v[i] = 1'b1;
                2:       v[i] = ((k % p) < ton[i]);
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic chk_leds(input string tag);
        chk(tag, LED & model_mask(), model_led() & model_mask());
    endtask

    task automatic wr(input int ch, input logic [1:0] mode, input int unsigned per,
                      input int unsigned on, input int unsigned bur);
        for (int w = 0; w < 4 && !bus.cfg_ready; w++) tick();
        chk("wr_ready", bus.cfg_ready, 1);
        bus.cfg_valid   = 1'b1;
        bus.cfg_ch      = CH_W'(ch);
        bus.cfg_mode    = mode;
        bus.cfg_period  = CNT_W'(per);
        bus.cfg_on_time = CNT_W'(on);
        bus.cfg_burst   = 8'(bur);
        tick();
        bus.cfg_valid = 1'b0;
        if (ch < N_CH) begin
            acc_e[ch] = ecnt; tp[ch] = per; ton[ch] = on;
            case (mode)
                2'b00:   tm[ch] = 0;
                2'b01:   tm[ch] = 1;
                2'b10:   tm[ch] = 2;
                default: tm[ch] = (bur == 0) ? 0 : 3;
            endcase
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = 2'b00;
        bus.cfg_period = '0; bus.cfg_on_time = '0; bus.cfg_burst = '0;
        set_defaults();

        #2;
        chk("rst_led", LED, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.cfg_ready, 0);
        @(posedge main_clk); #1;
        chk("rst_hold_led", LED, 0);
        chk("rst_hold_ready", bus.cfg_ready, 0);

        // Default blink: period 16, on 8, cnt starts at 0
        reset_n = 1'b1;
        set_defaults();
        tick();
        chk("ready_up", bus.cfg_ready, 1);
        chk("dflt_first", LED, 4'hF);
        repeat (7) tick();
        chk("dflt_low", LED, 4'h0);
        repeat (8) tick();
        chk("dflt_wrap", LED, 4'hF);

        // ch0 OFF, ch3 ON, ch1 BLINK P=10 on=3; ch2 keeps its reset phase
        wr(0, 2'b00, 5, 2, 0);
        wr(3, 2'b01, 5, 2, 0);
        wr(1, 2'b10, 10, 3, 0);
        for (int k = 0; k < 25; k++) begin
            chk("blink_ch1", LED[1], ((k % 10) < 3) ? 1 : 0);
            chk_leds("blink_all");
            tick();
        end

        // ch2 BURST P=4 on=2 burst=3
        wr(2, 2'b11, 4, 2, 3);
        for (int k = 0; k < 16; k++) begin
            chk("burst_led", LED[2], (k < 12 && (k % 4) < 2) ? 1 : 0);
            chk("burst_done", done, (k == 12) ? 4'b0100 : 4'b0000);
            chk_leds("burst_oth");
            tick();
        end
        tm[2] = 0;

        // on=0, on=P, on>P
        wr(0, 2'b10, 5, 0, 0);
        wr(1, 2'b10, 5, 5, 0);
        wr(3, 2'b10, 5, 9, 0);
        repeat (12) begin
            chk("edge_on", LED, 4'b1010);
            tick();
        end
        // P=0 and P=1
        wr(0, 2'b10, 0, 1, 0);
        wr(1, 2'b10, 1, 1, 0);
        repeat (6) begin
            chk("edge_per", LED, 4'b1011);
            tick();
        end

        // valid held 4 clocks: accepts on 1st and 3rd edge only
        chk("hs_ready0", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch = 3'd3; bus.cfg_mode = 2'b00; bus.cfg_period = '0;
        bus.cfg_on_time = '0; bus.cfg_burst = '0;
        tick();
        chk("hs_ready1", bus.cfg_ready, 0);
        bus.cfg_ch = 3'd0;
        tick();
        chk("hs_ready2", bus.cfg_ready, 1);
        bus.cfg_ch = 3'd7; bus.cfg_mode = 2'b00;
        tick();
        chk("hs_ready3", bus.cfg_ready, 0);
        bus.cfg_ch = 3'd1;
        tick();
        chk("hs_ready4", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b0;
        tm[3] = 0;
        chk("hs_led", LED, 4'b0011);
        tick();
        chk("hs_led2", LED, 4'b0011);
        chk_leds("hs_model");

        // Rewrite a burst on its final wrap edge
        wr(2, 2'b11, 3, 1, 1);
        chk("rw_k0", LED[2], 1);
        tick();
        chk("rw_k1", LED[2], 0);
        tick();
        chk("rw_k2_done", done, 0);
        chk("rw_ready", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1; bus.cfg_ch = 3'd2; bus.cfg_mode = 2'b10;
        bus.cfg_period = CNT_W'(4); bus.cfg_on_time = CNT_W'(1); bus.cfg_burst = '0;
        tick();
        bus.cfg_valid = 1'b0;
        tm[2] = 2; tp[2] = 4; ton[2] = 1; acc_e[2] = ecnt;
        chk("rw_nodone", done, 0);
        chk("rw_led0", LED[2], 1);
        for (int k = 1; k < 7; k++) begin
            tick();
            chk("rw_done", done, 0);
            chk("rw_led", LED[2], ((k % 4) == 0) ? 1 : 0);
            chk_leds("rw_all");
        end

        // BURST with burst=0 behaves as OFF, done on the following edge
        wr(1, 2'b11, 4, 2, 0);
        chk("b0_led", LED[1], 0);
        chk("b0_done0", done, 0);
        tick();
        chk("b0_done1", done, 4'b0010);
        tick();
        chk("b0_done2", done, 0);
        chk_leds("b0_all");

        // Asynchronous reset mid-burst
        wr(2, 2'b11, 4, 2, 3);
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_led", LED, 0);
        chk("arst_done", done, 0);
        chk("arst_ready", bus.cfg_ready, 0);
        @(posedge main_clk); #1;
        chk("arst_hold", LED, 0);
        reset_n = 1'b1;
        set_defaults();
        tick();
        chk("arst_rel_led", LED, 4'hF);
        chk("arst_rel_ready", bus.cfg_ready, 1);
        repeat (10) begin
            tick();
            chk_leds("arst_blink");
            chk("arst_nodone", done, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
